// File: rtl/e1_pkg.sv
// Shared E1 constants and scheduler state codes for the TX bit path.
package e1_pkg;

  localparam int unsigned E1_TS_PER_FRAME = 32;
  localparam int unsigned E1_BITS_PER_TS  = 8;
  localparam logic [7:0]  E1_IDLE_OCTET   = 8'hFF;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSync  = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

endpackage

// File: rtl/e1_tx_bit_sched_if.sv
// Octet handshake from the upstream framer into the E1 TX bit scheduler.
interface e1_tx_bit_sched_if;

  logic [7:0] in_octet;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_octet, output in_valid, input in_ready);
  modport slave  (input in_octet, input in_valid, output in_ready);

endinterface

// File: rtl/e1_tx_nco.sv
// Fractional NCO: trimmed increment added to a phase accumulator; carry-out is the bit strobe.
module e1_tx_nco #(
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned TRIM_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clear,
  input  logic [ACC_W-1:0]  inc,
  input  logic [TRIM_W-1:0] trim,
  output logic              strobe
);

  localparam int unsigned SumW = ACC_W + 2;

  logic [ACC_W-1:0] acc_q;
  logic [SumW-1:0]  eff_raw;
  logic [ACC_W-1:0] eff;
  logic [ACC_W:0]   sum;

  always_comb begin
    eff_raw = {2'b00, inc} + {{(SumW - TRIM_W){trim[TRIM_W-1]}}, trim};
    // Keep the effective step in [1, 2^ACC_W-1] so a large negative trim never stalls or wraps.
    if (eff_raw[SumW-1] || (eff_raw == '0)) begin
      eff = ACC_W'(1);
    end else if (eff_raw[ACC_W]) begin
      eff = '1;
    end else begin
      eff = eff_raw[ACC_W-1:0];
    end
    sum    = {1'b0, acc_q} + {1'b0, eff};
    strobe = run & sum[ACC_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc_q <= '0;
    end else if (run) begin
      acc_q <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/e1_tx_bit_sched.sv
// E1 TX bit scheduler: NCO-paced MSB-first serialiser of framer octets with timeslot
// tracking, frame-start marking and all-ones substitution on underrun.
module e1_tx_bit_sched
  import e1_pkg::*;
#(
  parameter int unsigned      ACC_W   = 24,
  parameter logic [ACC_W-1:0] INC_DEF = ACC_W'(24'h111111),
  parameter int unsigned      TRIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [TRIM_W-1:0] cfg_trim,
  e1_tx_bit_sched_if.slave  up,
  output logic              out_data,
  output logic              out_valid,
  output logic [4:0]        ts_num,
  output logic              stat_frame_start,
  output logic              stat_underrun
);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [7:0]       sreg_q, sreg_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [2:0]       bit_q, bit_d;
  logic [4:0]       ts_q, ts_d;
  logic             data_q, data_d, valid_q, valid_d, fs_q, fs_d, ur_q, ur_d;
  logic [4:0]       ts_out_q, ts_out_d;
  logic             run, clear, strobe, xfer, last_bit, last_ts;

  assign run         = (state_q == StRun) || (state_q == StDrain);
  assign clear       = (state_q == StIdle);
  assign up.in_ready = !hold_full_q && (state_q != StIdle);
  assign xfer        = up.in_valid && up.in_ready;
  assign last_bit    = (bit_q == 3'(E1_BITS_PER_TS - 1));
  assign last_ts     = (ts_q == 5'(E1_TS_PER_FRAME - 1));

  e1_tx_nco #(
    .ACC_W  (ACC_W),
    .TRIM_W (TRIM_W)
  ) u_nco (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .clear  (clear),
    .inc    (inc_q),
    .trim   (cfg_trim),
    .strobe (strobe)
  );

  always_comb begin
    state_d     = state_q;
    inc_d       = inc_q;
    sreg_d      = sreg_q;
    hold_d      = xfer ? up.in_octet : hold_q;
    hold_full_d = hold_full_q | xfer;
    bit_d       = bit_q;
    ts_d        = ts_q;
    ts_out_d    = ts_out_q;
    data_d      = 1'b0;
    valid_d     = 1'b0;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        hold_full_d = 1'b0;
        ts_out_d    = '0;
        if (cfg_en) begin
          state_d = StSync;
          inc_d   = cfg_inc;
        end
      end
      StSync: begin
        if (!cfg_en) begin
          state_d     = StIdle;
          hold_full_d = 1'b0;
        end else if (hold_full_q) begin
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
          ts_d        = '0;
          bit_d       = '0;
          state_d     = StRun;
        end
      end
      StRun, StDrain: begin
        state_d = cfg_en ? StRun : StDrain;
        if (strobe) begin
          valid_d  = 1'b1;
          data_d   = sreg_q[7];
          ts_out_d = ts_q;
          fs_d     = (bit_q == '0) && (ts_q == '0);
          sreg_d   = {sreg_q[6:0], 1'b0};
          bit_d    = bit_q + 3'd1;
          if (last_bit) begin
            ts_d = ts_q + 5'd1;
            if ((state_q == StDrain) && !cfg_en && last_ts) begin
              state_d     = StIdle;
              hold_full_d = 1'b0;
            end else if (hold_full_q) begin
              // Old hold drains into sreg; an octet accepted this cycle refills it.
              sreg_d      = hold_q;
              hold_full_d = xfer;
            end else begin
              sreg_d = E1_IDLE_OCTET;
              ur_d   = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      inc_q       <= INC_DEF;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_q       <= '0;
      ts_q        <= '0;
      ts_out_q    <= '0;
      data_q      <= 1'b0;
      valid_q     <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      inc_q       <= inc_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_q       <= bit_d;
      ts_q        <= ts_d;
      ts_out_q    <= ts_out_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
    end
  end

  assign out_data         = data_q;
  assign out_valid        = valid_q;
  assign ts_num           = ts_out_q;
  assign stat_frame_start = fs_q;
  assign stat_underrun    = ur_q;

endmodule

// File: tb/tb_e1_tx_bit_sched.sv
// Bench for e1_tx_bit_sched: rate table, directed corner sequences and a cycle-level
// reference model (phase arithmetic + octet queue) checking every output each cycle.
module tb_e1_tx_bit_sched;

  localparam logic [23:0] INC_DEF = 24'h111111;
  localparam longint      TWO_ACC = 64'd1 << 24;
  localparam int PatAb = 0, PatCnt = 1, PatRnd = 2;

  logic       clk = 1'b0;
  logic       rst_n, cfg_en;
  logic [23:0] cfg_inc;
  logic [7:0] cfg_trim;
  logic       out_data, out_valid, stat_frame_start, stat_underrun;
  logic [4:0] ts_num;

  e1_tx_bit_sched_if up_if ();

  e1_tx_bit_sched #(
    .ACC_W   (24),
    .INC_DEF (INC_DEF),
    .TRIM_W  (8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_en           (cfg_en),
    .cfg_inc          (cfg_inc),
    .cfg_trim         (cfg_trim),
    .up               (up_if),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .ts_num           (ts_num),
    .stat_frame_start (stat_frame_start),
    .stat_underrun    (stat_underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Framer stub: counts accepted octets, presents the next one after each edge.
  int  pat = PatAb;
  int  vprob = 100;
  bit  feed = 1'b0;
  bit  starve = 1'b0;
  int  sent = 0;

  always @(posedge clk) begin
    if (!rst_n) sent = 0;
    else if (up_if.in_valid && up_if.in_ready) sent++;
    #1;
    case (pat)
      PatAb:   up_if.in_octet = sent[0] ? 8'h3C : 8'hA5;
      PatCnt:  up_if.in_octet = 8'h10 + 8'(sent);
      default: up_if.in_octet = 8'($urandom);
    endcase
    up_if.in_valid = feed && (int'($urandom_range(99, 0)) < vprob)
                     && !(starve && sent == 5 && ts_num != 5'd5);
  end

  // Reference model: evaluated before each rising edge from the inputs then present.
  int          m_mode;  // 0 idle, 1 waiting for first octet, 2 running, 3 draining
  longint      m_phase, m_inc;
  int          m_pos;   // bit position in frame, 0..255
  logic [7:0]  m_cur;
  logic [7:0]  m_hold[$];
  logic        e_valid = 0, e_data = 0, e_fs = 0, e_ur = 0, e_ready = 0;
  logic [4:0]  e_ts = 0;

  task automatic model_step();
    bit     xfer, stb;
    int     prev;
    longint eff;
    e_valid = 0; e_data = 0; e_fs = 0; e_ur = 0;
    if (!rst_n) begin
      m_mode = 0; m_phase = 0; m_inc = INC_DEF; m_pos = 0; m_cur = 0; e_ts = 0;
      m_hold.delete();
    end else begin
      xfer = up_if.in_valid && m_hold.size() == 0 && m_mode != 0;
      prev = m_mode;
      case (prev)
        0: begin
          m_phase = 0; e_ts = 0;
          if (cfg_en) begin m_mode = 1; m_inc = longint'(cfg_inc); end
        end
        1: begin
          if (!cfg_en) m_mode = 0;
          else if (m_hold.size() > 0) begin
            m_cur = m_hold.pop_front(); m_pos = 0; m_mode = 2;
          end
        end
        default: begin
          m_mode = cfg_en ? 2 : 3;
          eff = m_inc + longint'($signed(cfg_trim));
          if (eff < 1) eff = 1;
          if (eff > TWO_ACC - 1) eff = TWO_ACC - 1;
          m_phase += eff;
          stb = m_phase >= TWO_ACC;
          if (stb) begin
            m_phase -= TWO_ACC;
            e_valid = 1;
            e_data  = m_cur[7 - (m_pos % 8)];
            e_fs    = (m_pos == 0);
            e_ts    = 5'(m_pos / 8);
            m_pos   = (m_pos + 1) % 256;
            if (m_pos % 8 == 0) begin
              if (prev == 3 && !cfg_en && m_pos == 0) m_mode = 0;
              else if (m_hold.size() > 0) m_cur = m_hold.pop_front();
              else begin m_cur = 8'hFF; e_ur = 1; end
            end
          end
        end
      endcase
      if (xfer) m_hold.push_back(up_if.in_octet);
      if (m_mode == 0) m_hold.delete();
    end
    e_ready = (m_hold.size() == 0) && (m_mode != 0);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_out_valid", out_valid, e_valid);
      chk("m_out_data", out_data, e_data);
      chk("m_ts_num", ts_num, e_ts);
      chk("m_frame_start", stat_frame_start, e_fs);
      chk("m_underrun", stat_underrun, e_ur);
      chk("m_in_ready", up_if.in_ready, e_ready);
    end
    model_step();
  end

  task automatic do_reset();
    rst_n = 0; cfg_en = 0; starve = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_ts_num"}, ts_num, 0);
    chk({tag, "_frame_start"}, stat_frame_start, 0);
    chk({tag, "_underrun"}, stat_underrun, 0);
    chk({tag, "_in_ready"}, up_if.in_ready, 0);
  endtask

  task automatic wait_for(input int ts, input bit need_fs, input int budget, input string nm);
    int t = 0;
    while (!(out_valid && (need_fs ? stat_frame_start : (ts_num == 5'(ts)))) && t < budget) begin
      tick(); t++;
    end
    chk({nm, "_reached"}, (t < budget), 1);
  endtask

  logic       cbits[256];
  logic [4:0] cts[256];
  int         c_ur;

  task automatic collect(input int nbits, input int budget);
    int got = 0, t = 0;
    c_ur = 0;
    while (got < nbits && t < budget) begin
      if (out_valid) begin cbits[got] = out_data; cts[got] = ts_num; got++; end
      if (stat_underrun) c_ur++;
      tick(); t++;
    end
    chk("collect_done", got, nbits);
  endtask

  function automatic logic [7:0] octet_at(input int ts);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[7 - i] = cbits[ts * 8 + i];
    return o;
  endfunction

  typedef struct {
    logic [23:0] inc;
    logic [7:0]  trim;
    int          win;
    int          lo;
    int          hi;
  } rate_vec_t;

  rate_vec_t rv[7];

  initial begin
    int         n, bad, gap, last_ts, n31, quiet, t;
    logic [15:0] v, m;
    int         vp[4];

    rv[0] = '{24'h111111, 8'h00, 3000, 199, 200};
    rv[1] = '{24'h400000, 8'h00, 400, 100, 100};
    rv[2] = '{24'h400000, 8'h10, 4096, 1024, 1025};
    rv[3] = '{24'h400000, 8'hF0, 4096, 1023, 1024};
    rv[4] = '{24'h000005, 8'h80, 500, 0, 0};
    rv[5] = '{24'h200000, 8'hF0, 800, 99, 100};
    rv[6] = '{24'h0AAAAB, 8'h00, 2400, 100, 101};
    vp = '{1, 10, 60, 100};

    rst_n = 0; cfg_en = 0; cfg_inc = INC_DEF; cfg_trim = 0;
    up_if.in_valid = 0; up_if.in_octet = 0;
    tick();
    chk_on = 1;
    do_reset();
    check_quiet("reset");

    // Strobe rate under various increments/trims, including clamp at 1.
    foreach (rv[i]) begin
      do_reset();
      cfg_inc = rv[i].inc; cfg_trim = rv[i].trim; pat = PatRnd; vprob = 100; feed = 1;
      cfg_en = 1;
      repeat (40) tick();
      n = 0;
      repeat (rv[i].win) begin tick(); if (out_valid) n++; end
      n_chk++;
      if (n < rv[i].lo || n > rv[i].hi) begin
        n_err++;
        $display("FAIL rate[%0d]: got %0d strobes expected %0d..%0d", i, n, rv[i].lo, rv[i].hi);
      end
    end

    // Nominal increment: strobe spacing 15 or 16 cycles.
    do_reset();
    cfg_inc = INC_DEF; cfg_trim = 0; cfg_en = 1;
    wait_for(0, 1, 400, "spacing_start");
    n = 0; bad = 0; gap = 0;
    while (n < 100 && gap < 100) begin
      tick(); gap++;
      if (out_valid) begin
        if (gap < 15 || gap > 16) bad++;
        n++; gap = 0;
      end
    end
    chk("spacing_strobes", n, 100);
    chk("spacing_bad", bad, 0);

    // A5 then 3C, MSB first, timeslots 0 then 1.
    do_reset();
    cfg_inc = 24'h400000; cfg_trim = 0; pat = PatAb; cfg_en = 1;
    wait_for(0, 1, 200, "ab_start");
    collect(16, 200);
    for (int i = 0; i < 16; i++) begin
      v[15 - i] = cbits[i];
      m[15 - i] = (cts[i] == 5'd1);
    end
    chk("ab_bits", v, 16'hA53C);
    chk("ab_ts_steps", m, 16'h00FF);

    // Starve exactly one octet so TS5 underruns.
    do_reset();
    pat = PatCnt; starve = 1; cfg_en = 1;
    wait_for(0, 1, 200, "starve_start");
    collect(64, 600);
    chk("starve_ts4", octet_at(4), 8'h14);
    chk("starve_ts5", octet_at(5), 8'hFF);
    chk("starve_ts6", octet_at(6), 8'h15);
    chk("starve_ts7", octet_at(7), 8'h16);
    chk("starve_ur_pulses", c_ur, 1);
    starve = 0;

    // Drop enable mid-frame: drain to TS31 bit 7, then idle.
    wait_for(10, 0, 3000, "drain_ts10");
    cfg_en = 0;
    last_ts = 0; n31 = 0; quiet = 0; t = 0;
    while (quiet < 100 && t < 4000) begin
      tick(); t++;
      if (out_valid) begin
        last_ts = ts_num; quiet = 0;
        if (ts_num == 5'd31) n31++;
      end else quiet++;
    end
    chk("drain_ended", (quiet >= 100), 1);
    chk("drain_last_ts", last_ts, 31);
    chk("drain_ts31_bits", n31, 8);
    n = 0;
    repeat (200) begin tick(); if (out_valid) n++; end
    chk("idle_no_strobes", n, 0);
    chk("idle_in_ready", up_if.in_ready, 0);
    chk("idle_ts_num", ts_num, 0);
    cfg_en = 1;
    tick();
    chk("sync_in_ready", up_if.in_ready, 1);
    chk("sync_out_valid", out_valid, 0);

    // One-cycle reset in the middle of TS17.
    wait_for(17, 0, 3000, "rst_ts17");
    rst_n = 0;
    tick();
    check_quiet("midreset");
    rst_n = 1;

    // Randomised segments against the reference model.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      cfg_inc = 24'($urandom_range(32'h600000, 32'h080000));
      cfg_trim = 8'($urandom); pat = PatRnd; vprob = vp[s]; feed = 1;
      cfg_en = 1;
      for (int c = 0; c < 5000; c++) begin
        tick();
        if (c % 250 == 249) cfg_trim = 8'($urandom);
        if (c % 1500 == 1499) cfg_en = ~cfg_en;
      end
    end

    @(negedge clk);
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
